// File: rtl/stream_demux_1to4.sv
// Registered 1:4 valid/ready stream demultiplexer with packet-atomic routing.
// Optional per-channel packet counters are enabled by defining STREAM_DEMUX_PKT_COUNT_EN.
module stream_demux_1to4 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic [1:0]   sel,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready
`ifdef STREAM_DEMUX_PKT_COUNT_EN
    ,
    output logic [63:0]  pkt_cnt
`endif
);

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     lock_ch_q, lock_ch_d;
    logic [NCH-1:0] valid_q, valid_d;
    logic [W-1:0]   data_q, data_d;
    logic           last_q, last_d;

    logic           out_hs;
    logic           accept;
    logic [1:0]     dest;

    // Holding register and routing FSM; out_valid doubles as the register's full/channel tag.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;

        out_hs   = |(valid_q & out_ready);
        in_ready = ~(|valid_q) | out_hs;
        accept   = in_valid & in_ready;
        dest     = (state_q == LOCK) ? lock_ch_q : sel;

        if (accept) begin
            valid_d = NCH'(4'b0001 << dest);
            data_d  = in_data;
            last_d  = in_last;
        end else if (out_hs) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (accept && !in_last) begin
                    state_d   = LOCK;
                    lock_ch_d = sel;
                end
            end
            LOCK: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= 2'd0;
            valid_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

`ifdef STREAM_DEMUX_PKT_COUNT_EN
    logic [CW-1:0] cnt_q [NCH];
    logic [CW-1:0] cnt_d [NCH];

    // A packet is counted when its last beat leaves on its channel; counters wrap.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(valid_q[i] & out_ready[i] & last_q);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pkt_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
